ub_access_arbiter: RTL and testbench



---
 rtl/ub_access_arbiter_if.sv | 52 +++++
 rtl/ub_access_arbiter.sv | 116 +++++++++++
 tb/tb_ub_access_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ub_access_arbiter_if.sv
// Unified-buffer access bus: host and compute request ports plus the single UB read/write port.
// The arbiter takes the slave view; the requesters and the UB take the master view.
interface ub_access_arbiter_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 8
);
  logic                  host_rd_req;
  logic [ADDR_WIDTH-1:0] host_rd_addr;
  logic                  host_rd_gnt;
  logic [DATA_WIDTH-1:0] host_rd_data;
  logic                  host_rd_valid;
  logic                  host_wr_req;
  logic [ADDR_WIDTH-1:0] host_wr_addr;
  logic [DATA_WIDTH-1:0] host_wr_data;
  logic                  host_wr_gnt;

  logic                  cmp_rd_req;
  logic [ADDR_WIDTH-1:0] cmp_rd_addr;
  logic                  cmp_rd_gnt;
  logic [DATA_WIDTH-1:0] cmp_rd_data;
  logic                  cmp_rd_valid;
  logic                  cmp_wr_req;
  logic [ADDR_WIDTH-1:0] cmp_wr_addr;
  logic [DATA_WIDTH-1:0] cmp_wr_data;
  logic                  cmp_wr_gnt;

  logic                  ub_rd_en;
  logic [ADDR_WIDTH:0]   ub_rd_addr;
  logic [DATA_WIDTH-1:0] ub_rd_data;
  logic                  ub_rd_valid;
  logic                  ub_wr_en;
  logic [ADDR_WIDTH:0]   ub_wr_addr;
  logic [DATA_WIDTH-1:0] ub_wr_data;

  modport slave (
    input  host_rd_req, host_rd_addr, host_wr_req, host_wr_addr, host_wr_data,
    input  cmp_rd_req, cmp_rd_addr, cmp_wr_req, cmp_wr_addr, cmp_wr_data,
    input  ub_rd_data, ub_rd_valid,
    output host_rd_gnt, host_rd_data, host_rd_valid, host_wr_gnt,
    output cmp_rd_gnt, cmp_rd_data, cmp_rd_valid, cmp_wr_gnt,
    output ub_rd_en, ub_rd_addr, ub_wr_en, ub_wr_addr, ub_wr_data
  );

  modport master (
    output host_rd_req, host_rd_addr, host_wr_req, host_wr_addr, host_wr_data,
    output cmp_rd_req, cmp_rd_addr, cmp_wr_req, cmp_wr_addr, cmp_wr_data,
    output ub_rd_data, ub_rd_valid,
    input  host_rd_gnt, host_rd_data, host_rd_valid, host_wr_gnt,
    input  cmp_rd_gnt, cmp_rd_data, cmp_rd_valid, cmp_wr_gnt,
    input  ub_rd_en, ub_rd_addr, ub_wr_en, ub_wr_addr, ub_wr_data
  );
endinterface

// File: rtl/ub_access_arbiter.sv
// Round-robin arbiter for the unified buffer's read and write ports with ping-pong
// bank ownership: host owns fill_bank, compute owns the other; banks swap once both are done.
module ub_access_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ub_access_arbiter_if.slave  bus,
  input  logic                host_done,
  input  logic                cmp_done,
  output logic                fill_bank,
  output logic                swap_busy,
  output logic [7:0]          swap_count
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWAP = 2'd2} state_e;

  state_e                state_q, state_d;
  logic                  host_flag_q, host_flag_d;
  logic                  cmp_flag_q, cmp_flag_d;
  logic                  rd_prio_host_q, wr_prio_host_q;
  logic                  rd_host_q, rd_cmp_q;
  logic                  grant_ok;
  logic                  host_rd_gnt, cmp_rd_gnt, host_wr_gnt, cmp_wr_gnt;
  logic [ADDR_WIDTH:0]   rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Priority bit set means host wins a tie; otherwise compute does.
  always_comb begin
    grant_ok    = (state_q == RUN);
    host_rd_gnt = grant_ok & bus.host_rd_req & (~bus.cmp_rd_req | rd_prio_host_q);
    cmp_rd_gnt  = grant_ok & bus.cmp_rd_req & (~bus.host_rd_req | ~rd_prio_host_q);
    host_wr_gnt = grant_ok & bus.host_wr_req & (~bus.cmp_wr_req | wr_prio_host_q);
    cmp_wr_gnt  = grant_ok & bus.cmp_wr_req & (~bus.host_wr_req | ~wr_prio_host_q);

    rd_addr = '0;
    if (host_rd_gnt)     rd_addr = {fill_bank, bus.host_rd_addr};
    else if (cmp_rd_gnt) rd_addr = {~fill_bank, bus.cmp_rd_addr};

    wr_addr = '0;
    wr_data = '0;
    if (host_wr_gnt) begin
      wr_addr = {fill_bank, bus.host_wr_addr};
      wr_data = bus.host_wr_data;
    end else if (cmp_wr_gnt) begin
      wr_addr = {~fill_bank, bus.cmp_wr_addr};
      wr_data = bus.cmp_wr_data;
    end
  end

  assign bus.host_rd_gnt   = host_rd_gnt;
  assign bus.cmp_rd_gnt    = cmp_rd_gnt;
  assign bus.host_wr_gnt   = host_wr_gnt;
  assign bus.cmp_wr_gnt    = cmp_wr_gnt;
  assign bus.ub_rd_en      = host_rd_gnt | cmp_rd_gnt;
  assign bus.ub_rd_addr    = rd_addr;
  assign bus.ub_wr_en      = host_wr_gnt | cmp_wr_gnt;
  assign bus.ub_wr_addr    = wr_addr;
  assign bus.ub_wr_data    = wr_data;
  assign bus.host_rd_data  = bus.ub_rd_data;
  assign bus.cmp_rd_data   = bus.ub_rd_data;
  assign bus.host_rd_valid = bus.ub_rd_valid & rd_host_q;
  assign bus.cmp_rd_valid  = bus.ub_rd_valid & rd_cmp_q;
  assign swap_busy         = (state_q != RUN);

  always_comb begin
    state_d     = state_q;
    host_flag_d = host_flag_q;
    cmp_flag_d  = cmp_flag_q;
    unique case (state_q)
      RUN: begin
        host_flag_d = host_flag_q | host_done;
        cmp_flag_d  = cmp_flag_q | cmp_done;
        if (host_flag_d && cmp_flag_d) state_d = DRAIN;
      end
      DRAIN: state_d = SWAP;
      SWAP: begin
        state_d     = RUN;
        host_flag_d = 1'b0;
        cmp_flag_d  = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  // Owner tag is cleared by reset so a read in flight at reset never produces a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      host_flag_q    <= 1'b0;
      cmp_flag_q     <= 1'b0;
      rd_prio_host_q <= 1'b0;
      wr_prio_host_q <= 1'b0;
      rd_host_q      <= 1'b0;
      rd_cmp_q       <= 1'b0;
      fill_bank      <= 1'b0;
      swap_count     <= 8'd0;
    end else begin
      state_q     <= state_d;
      host_flag_q <= host_flag_d;
      cmp_flag_q  <= cmp_flag_d;
      rd_host_q   <= host_rd_gnt;
      rd_cmp_q    <= cmp_rd_gnt;
      if (host_rd_gnt)     rd_prio_host_q <= 1'b0;
      else if (cmp_rd_gnt) rd_prio_host_q <= 1'b1;
      if (host_wr_gnt)     wr_prio_host_q <= 1'b0;
      else if (cmp_wr_gnt) wr_prio_host_q <= 1'b1;
      if (state_q == SWAP) begin
        fill_bank  <= ~fill_bank;
        swap_count <= swap_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ub_access_arbiter.sv
// Bench for ub_access_arbiter: a vector table with a read-return scoreboard, then
// hand-written reset-during-read and swap-counter wrap sequences.
module tb_ub_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ub_clr;
  logic       host_done, cmp_done;
  logic       fill_bank, swap_busy;
  logic [7:0] swap_count;

  ub_access_arbiter_if #(.DATA_WIDTH(256), .ADDR_WIDTH(8)) bus ();

  ub_access_arbiter #(.DATA_WIDTH(256), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .host_done  (host_done),
    .cmp_done   (cmp_done),
    .fill_bank  (fill_bank),
    .swap_busy  (swap_busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  // Behavioural UB: 1-cycle read latency, read-old-data on same-address write.
  logic [255:0] mem [512];
  logic [511:0] mem_vld;
  always @(posedge clk) begin
    if (ub_clr) mem_vld <= '0;
    else if (bus.ub_wr_en) begin
      mem[bus.ub_wr_addr]     <= bus.ub_wr_data;
      mem_vld[bus.ub_wr_addr] <= 1'b1;
    end
    bus.ub_rd_valid <= bus.ub_rd_en;
    bus.ub_rd_data  <= (bus.ub_rd_en && mem_vld[bus.ub_rd_addr]) ? mem[bus.ub_rd_addr] : '0;
  end

  typedef struct {
    logic [3:0] req;   // {host_rd, cmp_rd, host_wr, cmp_wr}
    logic [7:0] hra, cra, hwa, cwa, hwd, cwd;
    logic [1:0] dn;    // {host_done, cmp_done}
    logic [3:0] eg;    // expected grants, same order as req
    logic       ebusy, efb;
    logic [7:0] ecnt;
  } vec_t;

  typedef struct {
    logic         host;
    logic [255:0] data;
  } sb_t;

  vec_t         vt [29];
  sb_t          sbq [$];
  logic [255:0] ref_mem [512];
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic vec_t v(logic [3:0] req, logic [7:0] hra, cra, hwa, cwa, hwd, cwd,
                             logic [1:0] dn, logic [3:0] eg, logic ebusy, efb, logic [7:0] ecnt);
    vec_t r;
    r.req = req; r.hra = hra; r.cra = cra; r.hwa = hwa; r.cwa = cwa; r.hwd = hwd; r.cwd = cwd;
    r.dn = dn; r.eg = eg; r.ebusy = ebusy; r.efb = efb; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    bus.host_rd_req  = r.req[3]; bus.host_rd_addr = r.hra;
    bus.cmp_rd_req   = r.req[2]; bus.cmp_rd_addr  = r.cra;
    bus.host_wr_req  = r.req[1]; bus.host_wr_addr = r.hwa; bus.host_wr_data = {32{r.hwd}};
    bus.cmp_wr_req   = r.req[0]; bus.cmp_wr_addr  = r.cwa; bus.cmp_wr_data  = {32{r.cwd}};
    host_done = r.dn[1];
    cmp_done  = r.dn[0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t          e;
    logic [8:0]   ra, wa;
    logic [255:0] wd;

    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    //         req      hra    cra    hwa    cwa    hwd    cwd    dn     eg       busy fb cnt
    vt[0]  = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 0, 8'd0);
    vt[1]  = v(4'b0010, 8'h00, 8'h00, 8'h05, 8'h00, 8'hA5, 8'h00, 2'b00, 4'b0010, 0, 0, 8'd0);
    vt[2]  = v(4'b1001, 8'h05, 8'h00, 8'h00, 8'h07, 8'h00, 8'h3C, 2'b00, 4'b1001, 0, 0, 8'd0);
    vt[3]  = v(4'b1100, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0100, 0, 0, 8'd0);
    vt[4]  = v(4'b1100, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b1000, 0, 0, 8'd0);
    vt[5]  = v(4'b1100, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0100, 0, 0, 8'd0);
    vt[6]  = v(4'b1100, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b1000, 0, 0, 8'd0);
    vt[7]  = v(4'b0111, 8'h00, 8'h07, 8'h06, 8'h08, 8'h11, 8'h22, 2'b00, 4'b0110, 0, 0, 8'd0);
    vt[8]  = v(4'b0011, 8'h00, 8'h00, 8'h09, 8'h08, 8'h33, 8'h22, 2'b00, 4'b0001, 0, 0, 8'd0);
    vt[9]  = v(4'b1010, 8'h09, 8'h00, 8'h09, 8'h00, 8'h33, 8'h00, 2'b00, 4'b1010, 0, 0, 8'd0);
    vt[10] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 4'b0000, 0, 0, 8'd0);
    vt[11] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 0, 8'd0);
    vt[12] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 0, 8'd0);
    vt[13] = v(4'b1000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 4'b1000, 0, 0, 8'd0);
    vt[14] = v(4'b1111, 8'h05, 8'h07, 8'h0A, 8'h0B, 8'h44, 8'h55, 2'b00, 4'b0000, 1, 0, 8'd0);
    vt[15] = v(4'b1111, 8'h05, 8'h07, 8'h0A, 8'h0B, 8'h44, 8'h55, 2'b11, 4'b0000, 1, 0, 8'd0);
    vt[16] = v(4'b0110, 8'h00, 8'h07, 8'h05, 8'h00, 8'h5A, 8'h00, 2'b00, 4'b0110, 0, 1, 8'd1);
    vt[17] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 4'b0000, 0, 1, 8'd1);
    vt[18] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 1, 8'd1);
    vt[19] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 4'b0000, 0, 1, 8'd1);
    vt[20] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 1, 1, 8'd1);
    vt[21] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 1, 1, 8'd1);
    vt[22] = v(4'b1000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b1000, 0, 0, 8'd2);
    vt[23] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 4'b0000, 0, 0, 8'd2);
    vt[24] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 1, 0, 8'd2);
    vt[25] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 1, 0, 8'd2);
    vt[26] = v(4'b1100, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0100, 0, 1, 8'd3);
    vt[27] = v(4'b1000, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b1000, 0, 1, 8'd3);
    vt[28] = v(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 4'b0000, 0, 1, 8'd3);

    rst_n  = 1'b0;
    ub_clr = 1'b1;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset fill_bank", fill_bank, 0);
    chk("reset swap_count", swap_count, 0);
    chk("reset host_rd_valid", bus.host_rd_valid, 0);
    rst_n  = 1'b1;
    ub_clr = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1 drive(vt[i]);
      #3;
      chk($sformatf("r%0d host_rd_gnt", i), bus.host_rd_gnt, vt[i].eg[3]);
      chk($sformatf("r%0d cmp_rd_gnt", i), bus.cmp_rd_gnt, vt[i].eg[2]);
      chk($sformatf("r%0d host_wr_gnt", i), bus.host_wr_gnt, vt[i].eg[1]);
      chk($sformatf("r%0d cmp_wr_gnt", i), bus.cmp_wr_gnt, vt[i].eg[0]);
      chk($sformatf("r%0d swap_busy", i), swap_busy, vt[i].ebusy);
      chk($sformatf("r%0d fill_bank", i), fill_bank, vt[i].efb);
      chk($sformatf("r%0d swap_count", i), swap_count, vt[i].ecnt);

      ra = vt[i].eg[3] ? {vt[i].efb, vt[i].hra} : vt[i].eg[2] ? {~vt[i].efb, vt[i].cra} : 9'd0;
      wa = vt[i].eg[1] ? {vt[i].efb, vt[i].hwa} : vt[i].eg[0] ? {~vt[i].efb, vt[i].cwa} : 9'd0;
      wd = vt[i].eg[1] ? {32{vt[i].hwd}} : vt[i].eg[0] ? {32{vt[i].cwd}} : 256'd0;
      chk($sformatf("r%0d ub_rd_en", i), bus.ub_rd_en, vt[i].eg[3] | vt[i].eg[2]);
      chk($sformatf("r%0d ub_wr_en", i), bus.ub_wr_en, vt[i].eg[1] | vt[i].eg[0]);
      chk($sformatf("r%0d ub_rd_addr", i), bus.ub_rd_addr, ra);
      chk($sformatf("r%0d ub_wr_addr", i), bus.ub_wr_addr, wa);
      chk($sformatf("r%0d ub_wr_data", i), bus.ub_wr_data, wd);

      // A read granted last cycle must return now, to its own side only.
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("r%0d host_rd_valid", i), bus.host_rd_valid, e.host);
        chk($sformatf("r%0d cmp_rd_valid", i), bus.cmp_rd_valid, !e.host);
        chk($sformatf("r%0d rd_data", i), e.host ? bus.host_rd_data : bus.cmp_rd_data, e.data);
      end else begin
        chk($sformatf("r%0d host_rd_valid idle", i), bus.host_rd_valid, 0);
        chk($sformatf("r%0d cmp_rd_valid idle", i), bus.cmp_rd_valid, 0);
      end
      if (vt[i].eg[3] | vt[i].eg[2]) begin
        e.host = vt[i].eg[3];
        e.data = ref_mem[ra];
        sbq.push_back(e);
      end
      if (vt[i].eg[1] | vt[i].eg[0]) ref_mem[wa] = wd;
    end
    chk("scoreboard drained", sbq.size(), 0);

    // Reset asserted while a granted read is still in flight: it must never return.
    @(posedge clk);
    #1 bus.host_rd_req = 1'b1; bus.host_rd_addr = 8'h05;
    #3 chk("inflight host_rd_gnt", bus.host_rd_gnt, 1);
    #1 rst_n = 1'b0;
    bus.host_rd_req = 1'b0;
    #1;
    chk("async fill_bank", fill_bank, 0);
    chk("async swap_count", swap_count, 0);
    chk("async swap_busy", swap_busy, 0);
    @(posedge clk);
    #4;
    chk("inflight host_rd_valid", bus.host_rd_valid, 0);
    chk("inflight cmp_rd_valid", bus.cmp_rd_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1 host_done = 1'b1; cmp_done = 1'b1;
      @(posedge clk);
      #1 host_done = 1'b0; cmp_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (i == 0)   chk("wrap first swap", swap_count, 1);
      if (i == 254) chk("wrap count 255", swap_count, 255);
    end
    chk("wrap count 0", swap_count, 0);
    chk("wrap fill_bank", fill_bank, 0);
    chk("wrap swap_busy", swap_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
